uart_rx_fsm: RTL and testbench

//  Frame controller for the UART receiver. Detects the start bit, runs the oversampling

---
 rtl/uart_rx_fsm_if.sv | 49 ++++
 rtl/uart_rx_fsm.sv | 207 ++++++++++++++++++++
 tb/tb_uart_rx_fsm.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fsm_if.sv
// Control bundle between the UART receive frame controller and its datapath
// (line input, majority sampler, deserializer and start/parity/stop checkers).
// The controller is the master; the datapath side is the slave.
interface uart_rx_fsm_if #(
  parameter int PRESC_W = 6
);
  // Line and configuration
  logic               RX_IN;
  logic               PAR_EN;
  logic [PRESC_W-1:0] prescale;

  // Checker results
  logic               strt_glitch;
  logic               par_err;
  logic               stp_err;

  // Counters and datapath sequencing
  logic [PRESC_W-1:0] edge_cnt;
  logic               edge_cnt_max;
  logic [3:0]         bit_cnt;
  logic               dat_samp_en;
  logic               take_sample;
  logic               deser_en;
  logic               strt_chk_en;
  logic               par_chk_en;
  logic               stp_chk_en;

  // Frame outcome pulses
  logic               data_valid;
  logic               frame_err;

  modport master (
    input  RX_IN, PAR_EN, prescale,
    input  strt_glitch, par_err, stp_err,
    output edge_cnt, edge_cnt_max, bit_cnt,
    output dat_samp_en, take_sample, deser_en,
    output strt_chk_en, par_chk_en, stp_chk_en,
    output data_valid, frame_err
  );

  modport slave (
    output RX_IN, PAR_EN, prescale,
    output strt_glitch, par_err, stp_err,
    input  edge_cnt, edge_cnt_max, bit_cnt,
    input  dat_samp_en, take_sample, deser_en,
    input  strt_chk_en, par_chk_en, stp_chk_en,
    input  data_valid, frame_err
  );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller. Detects the start bit, runs the oversampling
// edge counter and the data-bit counter, sequences the sampler, deserializer
// and checkers, and reports each frame as a one-cycle data_valid (clean frame)
// or frame_err (parity or stop error). Every output is a register: the next
// values are decoded from the next state and next counters.
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic          clk_RX,
  input  logic          rst,
  uart_rx_fsm_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);
  localparam logic [3:0]         LAST_BIT  = 4'(DATA_WIDTH - 1);

  // Oversample counter advance: wraps to 0 after the last edge of a bit.
  function automatic logic [PRESC_W-1:0] edge_step(input logic [PRESC_W-1:0] cnt,
                                                   input logic               at_max);
    return at_max ? '0 : cnt + PRESC_ONE;
  endfunction

  // Last oversample edge of a bit period.
  function automatic logic is_last_edge(input logic [PRESC_W-1:0] cnt,
                                        input logic [PRESC_W-1:0] presc);
    return cnt == (presc - PRESC_ONE);
  endfunction

  // Edge on which the majority sampler's result is valid (just past mid-bit).
  function automatic logic is_sample_edge(input logic [PRESC_W-1:0] cnt,
                                          input logic [PRESC_W-1:0] presc);
    return cnt == ((presc >> 1) + PRESC_ONE);
  endfunction

  // Registered state, counters and frame configuration
  state_t             state_q;
  logic [PRESC_W-1:0] edge_q;
  logic [3:0]         bit_q;
  logic               par_en_q;
  logic [PRESC_W-1:0] presc_q;
  logic               err_q;

  // Registered outputs
  logic               edge_max_q;
  logic               take_q;
  logic               samp_en_q;
  logic               deser_en_q;
  logic               strt_chk_q;
  logic               par_chk_q;
  logic               stp_chk_q;
  logic               dv_q;
  logic               fe_q;

  // Next-cycle values
  state_t             state_nxt;
  logic [PRESC_W-1:0] edge_nxt;
  logic [3:0]         bit_nxt;
  logic               par_en_nxt;
  logic [PRESC_W-1:0] presc_nxt;
  logic               err_nxt;
  logic               dv_nxt;
  logic               fe_nxt;
  logic               active_nxt;

  // Next-state, counter and error-latch decode for the frame sequence
  always_comb begin
    state_nxt  = state_q;
    edge_nxt   = edge_step(edge_q, edge_max_q);
    bit_nxt    = bit_q;
    par_en_nxt = par_en_q;
    presc_nxt  = presc_q;
    err_nxt    = err_q;
    dv_nxt     = 1'b0;
    fe_nxt     = 1'b0;

    case (state_q)
      IDLE: begin
        edge_nxt = '0;
        bit_nxt  = '0;
        if (!bus.RX_IN) begin
          // The detection cycle counts as edge 0 of the start bit, and the
          // frame configuration is frozen here for the rest of the frame.
          state_nxt  = START;
          edge_nxt   = PRESC_ONE;
          par_en_nxt = bus.PAR_EN;
          presc_nxt  = bus.prescale;
          err_nxt    = 1'b0;
        end
      end

      START: begin
        bit_nxt = '0;
        if (take_q && bus.strt_glitch) begin
          // Line went low only briefly: quietly drop back to idle.
          state_nxt = IDLE;
          edge_nxt  = '0;
        end else if (edge_max_q) begin
          state_nxt = DATA;
        end
      end

      DATA: begin
        if (edge_max_q) begin
          if (bit_q == LAST_BIT) begin
            state_nxt = par_en_q ? PARITY : STOP;
            bit_nxt   = '0;
          end else begin
            bit_nxt = bit_q + 4'd1;
          end
        end
      end

      PARITY: begin
        if (take_q && bus.par_err) begin
          err_nxt = 1'b1;
        end
        if (edge_max_q) begin
          state_nxt = STOP;
        end
      end

      STOP: begin
        if (take_q && bus.stp_err) begin
          err_nxt = 1'b1;
        end
        if (edge_max_q) begin
          state_nxt = IDLE;
          edge_nxt  = '0;
          bit_nxt   = '0;
          if (err_nxt) begin
            fe_nxt = 1'b1;
          end else begin
            dv_nxt = 1'b1;
          end
        end
      end

      default: begin
        // Unused encodings recover to idle.
        state_nxt = IDLE;
        edge_nxt  = '0;
        bit_nxt   = '0;
      end
    endcase

    active_nxt = (state_nxt != IDLE);
  end

  // Frame controller state, counters and registered outputs
  always_ff @(posedge clk_RX or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      edge_q     <= '0;
      bit_q      <= '0;
      par_en_q   <= 1'b0;
      presc_q    <= '0;
      err_q      <= 1'b0;
      edge_max_q <= 1'b0;
      take_q     <= 1'b0;
      samp_en_q  <= 1'b0;
      deser_en_q <= 1'b0;
      strt_chk_q <= 1'b0;
      par_chk_q  <= 1'b0;
      stp_chk_q  <= 1'b0;
      dv_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      edge_q     <= edge_nxt;
      bit_q      <= bit_nxt;
      par_en_q   <= par_en_nxt;
      presc_q    <= presc_nxt;
      err_q      <= err_nxt;
      edge_max_q <= active_nxt && is_last_edge(edge_nxt, presc_nxt);
      take_q     <= active_nxt && is_sample_edge(edge_nxt, presc_nxt);
      samp_en_q  <= active_nxt;
      deser_en_q <= (state_nxt == DATA);
      strt_chk_q <= (state_nxt == START);
      par_chk_q  <= (state_nxt == PARITY);
      stp_chk_q  <= (state_nxt == STOP);
      dv_q       <= dv_nxt;
      fe_q       <= fe_nxt;
    end
  end

  assign bus.edge_cnt     = edge_q;
  assign bus.edge_cnt_max = edge_max_q;
  assign bus.bit_cnt      = bit_q;
  assign bus.dat_samp_en  = samp_en_q;
  assign bus.take_sample  = take_q;
  assign bus.deser_en     = deser_en_q;
  assign bus.strt_chk_en  = strt_chk_q;
  assign bus.par_chk_en   = par_chk_q;
  assign bus.stp_chk_en   = stp_chk_q;
  assign bus.data_valid   = dv_q;
  assign bus.frame_err    = fe_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: a small behavioural datapath (sampler, LSB-first
// deserializer, start/parity/stop checkers) closes the loop around the
// controller; frame outcomes are predicted into a scoreboard and matched
// against the data_valid / frame_err pulses, including their cycle.
module tb_uart_rx_fsm;
  localparam int PW = 6;
  localparam int DW = 8;

  logic          clk_RX = 1'b0;
  logic          rst    = 1'b0;
  int            cyc    = 0;
  int            nchk   = 0;
  int            nfail  = 0;
  logic [DW-1:0] pdata  = '0;

  uart_rx_fsm_if #(.PRESC_W(PW)) bus ();

  uart_rx_fsm #(.DATA_WIDTH(DW), .PRESC_W(PW)) dut (
    .clk_RX(clk_RX),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk_RX = ~clk_RX;

  always @(posedge clk_RX) cyc <= cyc + 1;

  // Datapath model: checkers and deserializer driven by the controller
  assign bus.strt_glitch = bus.strt_chk_en & bus.take_sample & bus.RX_IN;
  assign bus.par_err     = bus.par_chk_en & bus.take_sample & (bus.RX_IN ^ (^pdata));
  assign bus.stp_err     = bus.stp_chk_en & bus.take_sample & ~bus.RX_IN;

  always @(posedge clk_RX) begin
    if (bus.deser_en && bus.take_sample) pdata <= {bus.RX_IN, pdata[DW-1:1]};
  end

  typedef struct {
    int          cyc;
    bit          good;
    logic [7:0]  data;
  } exp_t;

  typedef struct {
    int          p;
    bit          pe;
    logic [7:0]  data;
    bit          bad_par;
    bit          stop_bit;
    bit          scramble;
    bit          exp_good;
    int          exp_lat;
  } vec_t;

  exp_t sbq[$];
  int   pulse_log[$];
  exp_t mon_e;
  logic prev_pulse = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic logic [19:0] outs();
    return {bus.edge_cnt, bus.edge_cnt_max, bus.bit_cnt, bus.dat_samp_en,
            bus.take_sample, bus.deser_en, bus.strt_chk_en, bus.par_chk_en,
            bus.stp_chk_en, bus.data_valid, bus.frame_err};
  endfunction

  // Scoreboard: match each outcome pulse against the oldest prediction
  always @(negedge clk_RX) begin
    if (!rst) begin
      prev_pulse <= 1'b0;
    end else begin
      if (prev_pulse) chk("pulse_width", int'({bus.data_valid, bus.frame_err}), 0);
      if (bus.data_valid || bus.frame_err) begin
        pulse_log.push_back(cyc);
        if (sbq.size() == 0) begin
          nchk++;
          nfail++;
          $display("FAIL unexpected_pulse: got dv=%0b fe=%0b at cycle %0d, required no pulse",
                   bus.data_valid, bus.frame_err, cyc);
        end else begin
          mon_e = sbq.pop_front();
          chk("pulse_cycle", cyc, mon_e.cyc);
          chk("pulse_kind", int'({bus.data_valid, bus.frame_err}), mon_e.good ? 2 : 1);
          if (mon_e.good) chk("p_data", int'(pdata), int'(mon_e.data));
        end
      end
      prev_pulse <= bus.data_valid | bus.frame_err;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_RX);
    #1;
  endtask

  // Drives one frame starting in the current cycle (which becomes cycle 0)
  task automatic send_frame(input int p, input bit pe, input logic [7:0] data,
                            input bit bad_par, input bit stop_bit, input bit scramble,
                            input bit exp_good, input int exp_lat);
    logic [10:0] bits;
    int          nb;
    exp_t        e;
    bits    = 11'h7FF;
    bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) bits[k+1] = data[k];
    if (pe) begin
      bits[9]  = (^data) ^ bad_par;
      bits[10] = stop_bit;
      nb       = 11;
    end else begin
      bits[9]  = stop_bit;
      nb       = 10;
    end
    e.cyc  = cyc + exp_lat;
    e.good = exp_good;
    e.data = data;
    sbq.push_back(e);
    bus.prescale = PW'(p);
    bus.PAR_EN   = pe;
    for (int i = 0; i < nb; i++) begin
      bus.RX_IN = bits[i];
      if (i == 0 && scramble) begin
        step(1);
        bus.prescale = (p == 16) ? 6'd8 : 6'd16;
        bus.PAR_EN   = ~pe;
        step(p - 1);
      end else begin
        step(p);
      end
    end
    bus.RX_IN = 1'b1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 3000) begin
      step(1);
      n++;
    end
    chk("drain", sbq.size(), 0);
    step(4);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, %0d tests run", nchk);
    $fatal(1, "watchdog timeout");
  end

  initial begin
    vec_t vecs[8];
    int   base;
    logic [7:0] rd;

    vecs[0] = '{8,  1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 80};
    vecs[1] = '{16, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 176};
    vecs[2] = '{8,  1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 80};
    vecs[3] = '{16, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 176};
    vecs[4] = '{32, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b1, 352};
    vecs[5] = '{8,  1'b1, 8'h81, 1'b0, 1'b1, 1'b1, 1'b1, 88};
    vecs[6] = '{16, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 160};
    vecs[7] = '{8,  1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 88};

    bus.RX_IN    = 1'b1;
    bus.PAR_EN   = 1'b0;
    bus.prescale = 6'd8;

    // Reset and idle state
    rst = 1'b0;
    repeat (3) @(posedge clk_RX);
    #1;
    chk("reset_outs", int'(outs()), 0);
    rst = 1'b1;
    step(3);
    chk("idle_outs", int'(outs()), 0);

    // Table-driven frames
    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].p, vecs[i].pe, vecs[i].data, vecs[i].bad_par,
                 vecs[i].stop_bit, vecs[i].scramble, vecs[i].exp_good, vecs[i].exp_lat);
      wait_drain();
    end

    // Two-cycle low glitch on an idle line
    base = pulse_log.size();
    bus.prescale = 6'd8;
    bus.PAR_EN   = 1'b0;
    bus.RX_IN    = 1'b0;
    @(negedge clk_RX);
    chk("glitch_c0_samp_en", int'(bus.dat_samp_en), 0);
    step(1);
    @(negedge clk_RX);
    chk("glitch_c1_edge_cnt", int'(bus.edge_cnt), 1);
    chk("glitch_c1_strt_en", int'(bus.strt_chk_en), 1);
    step(1);
    bus.RX_IN = 1'b1;
    step(3);
    @(negedge clk_RX);
    chk("glitch_c5_take", int'(bus.take_sample), 1);
    step(1);
    @(negedge clk_RX);
    chk("glitch_c6_samp_en", int'(bus.dat_samp_en), 0);
    chk("glitch_c6_strt_en", int'(bus.strt_chk_en), 0);
    chk("glitch_c6_edge_cnt", int'(bus.edge_cnt), 0);
    step(20);
    chk("glitch_no_pulse", pulse_log.size(), base);

    // Back-to-back frames at prescale 32
    base = pulse_log.size();
    send_frame(32, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 320);
    send_frame(32, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 320);
    wait_drain();
    chk("b2b_pulses", pulse_log.size() - base, 2);
    if (pulse_log.size() >= base + 2)
      chk("b2b_gap", pulse_log[base+1] - pulse_log[base], 320);

    // Reset asserted during data bit 4, then a clean frame
    rd = 8'h6B;
    bus.prescale = 6'd8;
    bus.PAR_EN   = 1'b0;
    bus.RX_IN    = 1'b0;
    step(7);
    @(negedge clk_RX);
    chk("start_edge_max", int'(bus.edge_cnt_max), 1);
    chk("start_strt_en", int'(bus.strt_chk_en), 1);
    step(1);
    bus.RX_IN = rd[0];
    @(negedge clk_RX);
    chk("data0_deser_en", int'(bus.deser_en), 1);
    chk("data0_bit_cnt", int'(bus.bit_cnt), 0);
    for (int j = 1; j < 5; j++) begin
      step(8);
      bus.RX_IN = rd[j];
    end
    step(2);
    @(negedge clk_RX);
    chk("data4_bit_cnt", int'(bus.bit_cnt), 4);
    chk("data4_edge_cnt", int'(bus.edge_cnt), 2);
    rst = 1'b0;
    #1;
    chk("reset_async_outs", int'(outs()), 0);
    step(2);
    chk("reset_held_outs", int'(outs()), 0);
    rst = 1'b1;
    bus.RX_IN = 1'b1;
    step(5);
    send_frame(8, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0, 1'b1, 80);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", nchk, nfail);
    $finish;
  end

endmodule
